bcd_led_scan: RTL

//  Time-multiplexed 7-segment driver fed by cascaded decade counters.
//  - Takes NDIG packed BCD digits and scans one digit at a time onto a common-anode LED display.
//  - Snapshots the digits once per frame so the display never shows a partly updated value.
//  - Emits tick/frame strobes that other stages can use as clock enables.

---
 rtl/bcd_led_scan.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bcd_led_scan.sv
// Multiplexed common-anode 7-segment driver: per-frame digit snapshot, dark-gap scan, tick/frame strobes.
// Optional leading-zero suppression is enabled by defining LZ_BLANK_EN.
module bcd_led_scan #(
  parameter int unsigned NDIG    = 4,
  parameter int unsigned PRESC   = 50000,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                sys_clk,
  input  logic                clr,
  input  logic                ce,
  input  logic [4*NDIG-1:0]   bcd,
  input  logic [NDIG-1:0]     dp_en,
  input  logic                blank,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [NDIG-1:0]     an,
  output logic                tick,
  output logic                frame
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NDIG - 1);

  logic [PRESC_W-1:0] presc;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [4*NDIG-1:0]  shadow_bcd;
  logic [NDIG-1:0]    shadow_dp;
  logic               slot_end;
  logic [3:0]         digit;
  logic [NDIG-1:0]    lz_dark;
  logic               lit;
  logic [NDIG-1:0]    an_next;
  logic               dp_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end = (presc == PRESC_LAST);
    idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    digit    = shadow_bcd[4*idx +: 4];
  end

  // A digit is dark under suppression when it and every digit above it are zero.
  always_comb begin
    lz_dark = '0;
`ifdef LZ_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int unsigned k = NDIG - 1; k >= 1; k--) begin
        zero_run   = zero_run & (shadow_bcd[4*k +: 4] == 4'd0);
        lz_dark[k] = zero_run;
      end
    end
`endif
  end

  always_comb begin
    lit          = !blank && !slot_end && !lz_dark[idx];
    an_next      = '1;
    if (lit) an_next[idx] = 1'b0;
    dp_next      = lit ? ~shadow_dp[idx] : 1'b1;
  end

  always_ff @(posedge sys_clk or posedge clr) begin
    if (clr) begin
      presc      <= '0;
      idx        <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      tick       <= 1'b0;
      frame      <= 1'b0;
    end else begin
      tick  <= 1'b0;
      frame <= 1'b0;
      if (ce) begin
        if (slot_end) begin
          presc <= '0;
          idx   <= idx_next;
          tick  <= 1'b1;
          if (idx_next == '0) begin
            frame      <= 1'b1;
            shadow_bcd <= bcd;
            shadow_dp  <= dp_en;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge clr) begin
    if (clr) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= decode(digit);
      dp  <= dp_next;
    end
  end

endmodule
